regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port between NREQ writeback sources
//  (e.g. ALU writeback, multi-cycle mult/div result, memory load return).
//  Round-robin arbitration with valid/ready handshake per requester.
//  Drives ctrl_writeEnable / ctrl_writeReg / data_writeReg of regFile from a
//  registered output stage; publishes a pending-write mask for hazard logic.
// PARAMETERS
//  NREQ   2   number of requesters (2..8)
//  IDXW   1   width of grant index, = clog2(NREQ), min 1
// PORTS
//  clock             in   1        system clock, rising edge
//  ctrl_reset        in   1        asynchronous, active-high reset
//  stall             in   1        1 = no grants this cycle
//  req_valid         in   NREQ     bit i: requester i has a write pending
//  req_reg           in   5*NREQ   slice [5i+4:5i]: destination register of requester i
//  req_data          in   32*NREQ  slice [32i+31:32i]: write data of requester i
//  req_ready         out  NREQ     bit i: requester i accepted this cycle (combinational)
//  ctrl_writeEnable  out  1        write strobe to regFile (registered)
//  ctrl_writeReg     out  5        write address to regFile (registered)
//  data_writeReg     out  32       write data to regFile (registered)
//  last_grant        out  IDXW     index of most recently granted requester
//  pending_mask      out  32       bit r set if reg r is targeted by a valid request or output stage
// BEHAVIOUR
//  Reset (async, ctrl_reset=1): ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0,
//   last_grant=NREQ-1 (so requester 0 is first priority), req_ready=0 while reset is held.
//   Reset mid-transfer discards the output stage; that write never reaches regFile.
//  Arbitration (combinational each cycle, when stall=0):
//   - Search order starts at last_grant+1 and wraps modulo NREQ; first i with req_valid[i]=1 wins.
//   - Exactly one req_ready bit high for the winner, all others 0; none if stall=1 or no valid.
//   - Handshake completes when req_valid[i] & req_ready[i]; requester must hold
//     req_reg/req_data stable while req_valid=1 and not yet accepted.
//  Output stage (rising edge after acceptance of requester i):
//   - last_grant<=i.
//   - If req_reg slice != 0: ctrl_writeEnable<=1, ctrl_writeReg<=reg, data_writeReg<=data.
//   - If req_reg slice == 0: request is accepted (consumed) but ctrl_writeEnable<=0
//     (r0 is hardwired zero); last_grant still advances.
//   - No acceptance: ctrl_writeEnable<=0; ctrl_writeReg/data_writeReg hold previous value.
//   - Latency: accept in cycle N -> regFile write at edge ending cycle N+1. Throughput 1 write/cycle.
//  Same-register collisions: two valid requesters targeting the same reg are written
//   in grant order; the later grant's data is the final value. No merging.
//  stall=1: no acceptance, last_grant frozen, output stage drains (ctrl_writeEnable=0 next edge).
//  pending_mask: OR over i of onehot(req_reg_i) where req_valid[i]=1, OR onehot(ctrl_writeReg)
//   when ctrl_writeEnable=1; bit 0 always 0. Combinational.
//  Fairness: any continuously valid requester is granted within NREQ cycles of stall=0.
// TESTING
//  1 Reset: assert ctrl_reset mid-write (en=1, reg=5) -> en=0, reg=0, data=0, last_grant=NREQ-1 immediately.
//  2 Single req: valid[0], reg=3, data=0xDEADBEEF -> ready[0] same cycle; next edge en=1, reg=3, data=0xDEADBEEF.
//  3 Round-robin: both valid continuously (reg 7/9) -> grants alternate 0,1,0,1; regFile r7/r9 updated every other cycle.
//  4 r0 drop: valid[1], reg=0, data=0x1234 -> ready[1]=1, en stays 0, last_grant=1, regFile r0 reads 0.
//  5 Stall: both valid, stall=1 for 3 cycles -> ready=00, en=0 after 1 edge; on release requester last_grant+1 wins.
//  6 Collision: req0 reg=4 data=0x11, req1 reg=4 data=0x22, last_grant=1 -> r4=0x11 then r4=0x22; pending_mask[4]=1 until final write done.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: round-robin share of one regFile write port among NREQ sources.
// Latency: accept in cycle N (combinational ready) -> write strobe registered at the edge ending cycle N,
//          regFile commits at the edge ending N+1. Throughput 1 write/cycle.
// Backpressure: i_stall or reset holds every o_req_ready low; requesters keep reg/data stable until accepted.
//
// Ports:
//   i_clock            rising-edge clock
//   i_ctrl_reset       asynchronous active-high reset
//   i_stall            1 = no grants this cycle, output stage drains
//   i_req_valid        per-requester write pending
//   i_req_reg          5-bit destination per requester, slice [5i+4:5i]
//   i_req_data         32-bit data per requester, slice [32i+31:32i]
//   o_req_ready        one-hot acceptance for this cycle (combinational)
//   o_ctrl_writeEnable registered write strobe to regFile
//   o_ctrl_writeReg    registered write address to regFile
//   o_data_writeReg    registered write data to regFile
//   o_last_grant       index of the most recently accepted requester
//   o_pending_mask     registers targeted by a valid request or by the output stage

module regfile_wb_arbiter #(
    parameter int NREQ = 2,
    parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 i_clock,
    input  logic                 i_ctrl_reset,
    input  logic                 i_stall,
    input  logic [NREQ-1:0]      i_req_valid,
    input  logic [5*NREQ-1:0]    i_req_reg,
    input  logic [32*NREQ-1:0]   i_req_data,
    output logic [NREQ-1:0]      o_req_ready,
    output logic                 o_ctrl_writeEnable,
    output logic [4:0]           o_ctrl_writeReg,
    output logic [31:0]          o_data_writeReg,
    output logic [IDXW-1:0]      o_last_grant,
    output logic [31:0]          o_pending_mask
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic            r_we;
    logic [4:0]      r_wreg;
    logic [31:0]     r_wdata;
    logic [IDXW-1:0] r_last_grant;

    // ------------------------------------------------------------------
    // Round-robin search
    // ------------------------------------------------------------------
    // The search order (last_grant+1 .. wrap) is split into two ranges:
    // indices above last_grant ("hi") are searched first, then indices
    // at or below it ("lo"). Within each range the lowest index wins,
    // which the descending loop achieves by letting the last hit stick.
    logic            w_hi_vld;
    logic            w_lo_vld;
    logic [IDXW-1:0] w_hi_idx;
    logic [IDXW-1:0] w_lo_idx;
    logic [IDXW-1:0] w_grant_idx;
    logic            w_grant_vld;

    always_comb begin
        w_hi_vld = 1'b0;
        w_lo_vld = 1'b0;
        w_hi_idx = '0;
        w_lo_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_req_valid[i]) begin
                if (IDXW'(i) > r_last_grant) begin
                    w_hi_vld = 1'b1;
                    w_hi_idx = IDXW'(i);
                end else begin
                    w_lo_vld = 1'b1;
                    w_lo_idx = IDXW'(i);
                end
            end
        end
        w_grant_idx = w_hi_vld ? w_hi_idx : w_lo_idx;
        // Reset is folded in so ready stays low while reset is held.
        w_grant_vld = (w_hi_vld | w_lo_vld) & ~i_stall & ~i_ctrl_reset;
    end

    // ------------------------------------------------------------------
    // Ready decode and winner payload mux
    // ------------------------------------------------------------------
    logic [NREQ-1:0] w_req_ready;
    logic [4:0]      w_sel_reg;
    logic [31:0]     w_sel_data;

    always_comb begin
        w_req_ready = '0;
        w_sel_reg   = '0;
        w_sel_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant_vld && (w_grant_idx == IDXW'(i))) begin
                w_req_ready[i] = 1'b1;
                w_sel_reg      = i_req_reg[5*i +: 5];
                w_sel_data     = i_req_data[32*i +: 32];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    // A grant to r0 still consumes the request and advances the pointer,
    // but never raises the strobe: r0 is hardwired zero in the regFile.
    // Address/data hold when no write is issued so the regFile port is quiet.
    always_ff @(posedge i_clock or posedge i_ctrl_reset) begin
        if (i_ctrl_reset) begin
            r_we         <= 1'b0;
            r_wreg       <= '0;
            r_wdata      <= '0;
            r_last_grant <= IDXW'(NREQ - 1);
        end else if (w_grant_vld) begin
            r_last_grant <= w_grant_idx;
            r_we         <= (w_sel_reg != 5'd0);
            if (w_sel_reg != 5'd0) begin
                r_wreg  <= w_sel_reg;
                r_wdata <= w_sel_data;
            end
        end else begin
            r_we <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Pending-write mask for hazard detection
    // ------------------------------------------------------------------
    logic [31:0] w_pending;

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (i_req_valid[i]) begin
                w_pending[i_req_reg[5*i +: 5]] = 1'b1;
            end
        end
        if (r_we) begin
            w_pending[r_wreg] = 1'b1;
        end
        // r0 can never hold a pending value.
        w_pending[0] = 1'b0;
    end

    assign o_req_ready        = w_req_ready;
    assign o_ctrl_writeEnable = r_we;
    assign o_ctrl_writeReg    = r_wreg;
    assign o_data_writeReg    = r_wdata;
    assign o_last_grant       = r_last_grant;
    assign o_pending_mask     = w_pending;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int NREQ = 2;
    localparam int IDXW = 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 stall = 1'b0;
    logic [NREQ-1:0]      valid = '0;
    logic [5*NREQ-1:0]    regs = '0;
    logic [32*NREQ-1:0]   data = '0;
    logic [NREQ-1:0]      o_ready;
    logic                 o_en;
    logic [4:0]           o_reg;
    logic [31:0]          o_dat;
    logic [IDXW-1:0]      o_lg;
    logic [31:0]          o_mask;

    regfile_wb_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) dut (
        .i_clock            (clk),
        .i_ctrl_reset       (rst),
        .i_stall            (stall),
        .i_req_valid        (valid),
        .i_req_reg          (regs),
        .i_req_data         (data),
        .o_req_ready        (o_ready),
        .o_ctrl_writeEnable (o_en),
        .o_ctrl_writeReg    (o_reg),
        .o_data_writeReg    (o_dat),
        .o_last_grant       (o_lg),
        .o_pending_mask     (o_mask)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] rf [32];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    // The regFile mirror is written from whatever the DUT presents at the edge.
    task automatic step(input logic st, input logic [NREQ-1:0] v,
                        input logic [5*NREQ-1:0] r, input logic [32*NREQ-1:0] d,
                        input logic [NREQ-1:0] e_rdy, input logic [31:0] e_mask,
                        input logic e_en, input logic [4:0] e_reg,
                        input logic [31:0] e_dat, input logic [IDXW-1:0] e_lg);
        logic s_en;
        logic [4:0] s_reg;
        logic [31:0] s_dat;
        stall = st;
        valid = v;
        regs  = r;
        data  = d;
        @(negedge clk);
        chk("ready", 32'(o_ready), 32'(e_rdy));
        chk("pending_mask", o_mask, e_mask);
        s_en  = o_en;
        s_reg = o_reg;
        s_dat = o_dat;
        @(posedge clk);
        if (s_en) rf[s_reg] = s_dat;
        #1;
        chk("write_enable", 32'(o_en), 32'(e_en));
        chk("write_reg", 32'(o_reg), 32'(e_reg));
        chk("write_data", o_dat, e_dat);
        chk("last_grant", 32'(o_lg), 32'(e_lg));
    endtask

    typedef struct {
        logic        st;
        logic [1:0]  vld;
        logic [4:0]  r0, r1;
        logic [31:0] d0, d1;
        logic [1:0]  e_rdy;
        logic [31:0] e_mask;
        logic        e_en;
        logic [4:0]  e_reg;
        logic [31:0] e_dat;
        logic        e_lg;
    } vec_t;

    function automatic vec_t mk(logic st, logic [1:0] vld, logic [4:0] r0, logic [4:0] r1,
                                logic [31:0] d0, logic [31:0] d1, logic [1:0] e_rdy,
                                logic [31:0] e_mask, logic e_en, logic [4:0] e_reg,
                                logic [31:0] e_dat, logic e_lg);
        vec_t t;
        t.st = st; t.vld = vld; t.r0 = r0; t.r1 = r1; t.d0 = d0; t.d1 = d1;
        t.e_rdy = e_rdy; t.e_mask = e_mask; t.e_en = e_en; t.e_reg = e_reg;
        t.e_dat = e_dat; t.e_lg = e_lg;
        return t;
    endfunction

    vec_t tbl [14];

    // Reference model state for the random phase
    int          m_lg;
    logic        m_en;
    logic [4:0]  m_reg;
    logic [31:0] m_dat;
    logic        p_v [NREQ];
    logic [4:0]  p_r [NREQ];
    logic [31:0] p_d [NREQ];
    int          wt  [NREQ];
    logic              rs_st;
    logic [NREQ-1:0]   rs_v, rs_er;
    logic [5*NREQ-1:0] rs_r;
    logic [32*NREQ-1:0] rs_d;
    logic [31:0]       rs_em;
    int                rs_win;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;

        //               st    vld    r0    r1    d0            d1          rdy    mask        en    reg   data          lg
        tbl[0]  = mk(1'b0, 2'b01, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0,      2'b01, 32'h008, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0);
        tbl[1]  = mk(1'b0, 2'b00, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0,      2'b00, 32'h008, 1'b0, 5'd3, 32'hDEADBEEF, 1'b0);
        tbl[2]  = mk(1'b0, 2'b11, 5'd7, 5'd9, 32'hA7,       32'hB9,     2'b10, 32'h280, 1'b1, 5'd9, 32'hB9,       1'b1);
        tbl[3]  = mk(1'b0, 2'b11, 5'd7, 5'd9, 32'hA7,       32'hB9,     2'b01, 32'h280, 1'b1, 5'd7, 32'hA7,       1'b0);
        tbl[4]  = mk(1'b0, 2'b11, 5'd7, 5'd9, 32'hA7,       32'hB9,     2'b10, 32'h280, 1'b1, 5'd9, 32'hB9,       1'b1);
        tbl[5]  = mk(1'b0, 2'b11, 5'd7, 5'd9, 32'hA7,       32'hB9,     2'b01, 32'h280, 1'b1, 5'd7, 32'hA7,       1'b0);
        tbl[6]  = mk(1'b0, 2'b10, 5'd7, 5'd0, 32'hA7,       32'h1234,   2'b10, 32'h080, 1'b0, 5'd7, 32'hA7,       1'b1);
        tbl[7]  = mk(1'b1, 2'b11, 5'd4, 5'd4, 32'h11,       32'h22,     2'b00, 32'h010, 1'b0, 5'd7, 32'hA7,       1'b1);
        tbl[8]  = mk(1'b1, 2'b11, 5'd4, 5'd4, 32'h11,       32'h22,     2'b00, 32'h010, 1'b0, 5'd7, 32'hA7,       1'b1);
        tbl[9]  = mk(1'b1, 2'b11, 5'd4, 5'd4, 32'h11,       32'h22,     2'b00, 32'h010, 1'b0, 5'd7, 32'hA7,       1'b1);
        tbl[10] = mk(1'b0, 2'b11, 5'd4, 5'd4, 32'h11,       32'h22,     2'b01, 32'h010, 1'b1, 5'd4, 32'h11,       1'b0);
        tbl[11] = mk(1'b0, 2'b10, 5'd4, 5'd4, 32'h11,       32'h22,     2'b10, 32'h010, 1'b1, 5'd4, 32'h22,       1'b1);
        tbl[12] = mk(1'b0, 2'b00, 5'd4, 5'd4, 32'h11,       32'h22,     2'b00, 32'h010, 1'b0, 5'd4, 32'h22,       1'b1);
        tbl[13] = mk(1'b0, 2'b00, 5'd0, 5'd0, 32'h0,        32'h0,      2'b00, 32'h000, 1'b0, 5'd4, 32'h22,       1'b1);

        // Reset held with requests present: nothing accepted, outputs cleared.
        valid = 2'b11;
        regs  = {5'd2, 5'd1};
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", 32'(o_ready), 32'h0);
        chk("reset_en", 32'(o_en), 32'h0);
        chk("reset_reg", 32'(o_reg), 32'h0);
        chk("reset_data", o_dat, 32'h0);
        chk("reset_last_grant", 32'(o_lg), 32'(NREQ - 1));
        valid = '0;
        regs  = '0;
        rst   = 1'b0;

        // Directed table: single write, round-robin, r0 drop, stall, collision.
        for (int k = 0; k < 14; k++) begin
            step(tbl[k].st, tbl[k].vld, {tbl[k].r1, tbl[k].r0}, {tbl[k].d1, tbl[k].d0},
                 tbl[k].e_rdy, tbl[k].e_mask, tbl[k].e_en, tbl[k].e_reg, tbl[k].e_dat, tbl[k].e_lg);
            if (k == 11) chk("collision_first_write_r4", rf[4], 32'h11);
        end
        chk("rf_r3", rf[3], 32'hDEADBEEF);
        chk("rf_r7", rf[7], 32'hA7);
        chk("rf_r9", rf[9], 32'hB9);
        chk("rf_r4_final", rf[4], 32'h22);
        chk("rf_r0", rf[0], 32'h0);

        // Reset in the middle of a write: output stage discarded immediately.
        step(1'b0, 2'b01, {5'd0, 5'd5}, {32'h0, 32'h55}, 2'b01, 32'h020, 1'b1, 5'd5, 32'h55, 1'b0);
        rst = 1'b1;
        #1;
        chk("midreset_en", 32'(o_en), 32'h0);
        chk("midreset_reg", 32'(o_reg), 32'h0);
        chk("midreset_data", o_dat, 32'h0);
        chk("midreset_last_grant", 32'(o_lg), 32'(NREQ - 1));
        chk("midreset_ready", 32'(o_ready), 32'h0);
        @(negedge clk);
        valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 2'b00, '0, '0, 2'b00, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        chk("rf_r5_discarded", rf[5], 32'h0);

        // Random phase against the reference model.
        m_lg = NREQ - 1;
        m_en = 1'b0;
        m_reg = '0;
        m_dat = '0;
        for (int i = 0; i < NREQ; i++) begin
            p_v[i] = 1'b0; p_r[i] = '0; p_d[i] = '0; wt[i] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!p_v[i] && $urandom_range(2) != 0) begin
                    p_v[i] = 1'b1;
                    p_r[i] = 5'($urandom_range(7));
                    p_d[i] = $urandom;
                end
            end
            rs_st = ($urandom_range(4) == 0);
            for (int i = 0; i < NREQ; i++) begin
                rs_v[i]         = p_v[i];
                rs_r[5*i +: 5]  = p_r[i];
                rs_d[32*i +: 32] = p_d[i];
            end
            rs_win = -1;
            if (!rs_st) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (rs_win < 0 && p_v[(m_lg + k) % NREQ]) rs_win = (m_lg + k) % NREQ;
                end
            end
            rs_er = '0;
            if (rs_win >= 0) rs_er = NREQ'(1) << rs_win;
            rs_em = 32'h0;
            for (int i = 0; i < NREQ; i++) if (p_v[i]) rs_em[p_r[i]] = 1'b1;
            if (m_en) rs_em[m_reg] = 1'b1;
            rs_em[0] = 1'b0;
            if (rs_win >= 0) begin
                m_lg = rs_win;
                m_en = (p_r[rs_win] != 5'd0);
                if (m_en) begin
                    m_reg = p_r[rs_win];
                    m_dat = p_d[rs_win];
                end
            end else begin
                m_en = 1'b0;
            end
            step(rs_st, rs_v, rs_r, rs_d, rs_er, rs_em, m_en, m_reg, m_dat, IDXW'(m_lg));
            for (int i = 0; i < NREQ; i++) begin
                if (p_v[i] && !rs_st) wt[i]++;
                if (rs_win == i) begin
                    chk("fairness_within_nreq", 32'(wt[i] <= NREQ), 32'h1);
                    wt[i]  = 0;
                    p_v[i] = 1'b0;
                end
            end
        end
        chk("rf_r0_random", rf[0], 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
